// File: rtl/final_ctrl.sv
// ---------------------------------------------------------------------------
// final_ctrl -- trace-window controller.
//
// Turns a level trace-enable request into registered begin/pause events and
// keeps saturating counts of segments begun and of traced cycles. An
// end-of-run request drives a fixed-length flush and then parks the block in
// a terminal DONE state that only reset leaves.
//
// Ports:
//   clk_i          single clock, all state on posedge
//   reset_i        asynchronous active-low reset
//   arm_i          trace destination configured (level)
//   en_i           trace-enable request (level)
//   fini_i         end-of-run / flush request (level)
//   tracing_o      capture active (high exactly while in ON)
//   begin_v_o      one-cycle pulse: a segment began
//   pause_v_o      one-cycle pulse: a segment paused
//   fini_v_o       one-cycle pulse: flush completed
//   done_o         terminal state reached (sticky until reset)
//   seg_count_o    segments begun, saturating
//   trace_cycles_o cycles spent with tracing_o=1, saturating
//   overflow_o     sticky: either counter reached all-ones
//   dbg_state_o    current FSM state (OFF=0, ON=1, FLUSH=2, DONE=3)
//
// Handshake note: there is no valid/ready exchange here. Requests are plain
// levels sampled on every rising edge; every event output is a registered
// pulse that is high for exactly the one cycle following the edge at which
// the causing input was sampled, with no back-pressure.
//
// flush_cycles_p must lie in 1..255.
// ---------------------------------------------------------------------------
module final_ctrl #(
    parameter int cnt_width_p    = 32,
    parameter int seg_width_p    = 8,
    parameter int flush_cycles_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   arm_i,
    input  logic                   en_i,
    input  logic                   fini_i,
    output logic                   tracing_o,
    output logic                   begin_v_o,
    output logic                   pause_v_o,
    output logic                   fini_v_o,
    output logic                   done_o,
    output logic [seg_width_p-1:0] seg_count_o,
    output logic [cnt_width_p-1:0] trace_cycles_o,
    output logic                   overflow_o,
    output logic [1:0]             dbg_state_o
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Flush counter value seen in the last FLUSH cycle.
    localparam logic [7:0] FLUSH_LAST = 8'(flush_cycles_p - 1);

    // "One below all-ones": the value from which an increment saturates.
    localparam logic [seg_width_p-1:0] SEG_MAX  = '1;
    localparam logic [seg_width_p-1:0] SEG_NEAR = SEG_MAX - 1'b1;
    localparam logic [cnt_width_p-1:0] CYC_MAX  = '1;
    localparam logic [cnt_width_p-1:0] CYC_NEAR = CYC_MAX - 1'b1;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [7:0] flush_cnt_q;
    logic [7:0] flush_cnt_d;
    logic       begin_d;
    logic       pause_d;
    logic       fini_d;
    logic       seg_inc;
    logic       cyc_inc;
    logic       seg_hit;
    logic       cyc_hit;

    assign dbg_state_o = state_q;

    // Next-state and pulse decode. fini_i is tested first in every state so
    // it always wins over en_i/arm_i.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        begin_d     = 1'b0;
        pause_d     = 1'b0;
        fini_d      = 1'b0;
        seg_inc     = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (fini_i) begin
                    // Without a configured destination there is nothing to
                    // flush, so jump straight to DONE without a fini pulse.
                    if (arm_i) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (arm_i && en_i) begin
                    state_d = ST_ON;
                    begin_d = 1'b1;
                    seg_inc = 1'b1;
                end
            end
            ST_ON: begin
                if (fini_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 8'd0;
                    pause_d     = 1'b1;
                end else if (!en_i || !arm_i) begin
                    state_d = ST_OFF;
                    pause_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_DONE;
                    fini_d  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // Each cycle spent in ON is counted on the edge that ends it.
    assign cyc_inc = (state_q == ST_ON);

    // Saturation is flagged on the increment that lands on all-ones.
    assign seg_hit = seg_inc && (seg_count_o == SEG_NEAR);
    assign cyc_hit = cyc_inc && (trace_cycles_o == CYC_NEAR);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q        <= ST_OFF;
            flush_cnt_q    <= 8'd0;
            tracing_o      <= 1'b0;
            begin_v_o      <= 1'b0;
            pause_v_o      <= 1'b0;
            fini_v_o       <= 1'b0;
            done_o         <= 1'b0;
            seg_count_o    <= '0;
            trace_cycles_o <= '0;
            overflow_o     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tracing_o   <= (state_d == ST_ON);
            done_o      <= (state_d == ST_DONE);
            begin_v_o   <= begin_d;
            pause_v_o   <= pause_d;
            fini_v_o    <= fini_d;
            if (seg_inc && (seg_count_o != SEG_MAX)) begin
                seg_count_o <= seg_count_o + 1'b1;
            end
            if (cyc_inc && (trace_cycles_o != CYC_MAX)) begin
                trace_cycles_o <= trace_cycles_o + 1'b1;
            end
            if (seg_hit || cyc_hit) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_final_ctrl.sv
// ---------------------------------------------------------------------------
// tb_final_ctrl -- directed scoreboard bench for final_ctrl.
// Narrow counters (2-bit segments, 4-bit cycles) make both saturation paths
// reachable in a short run.
// ---------------------------------------------------------------------------
module tb_final_ctrl;

    localparam int SW = 2;
    localparam int CW = 4;
    localparam int FL = 4;
    localparam int VW = 6 + SW + CW;
    localparam int SEG_TOP = (1 << SW) - 1;
    localparam int CYC_TOP = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk = ~clk;

    logic          arm_i = 1'b0;
    logic          en_i = 1'b0;
    logic          fini_i = 1'b0;
    logic          tracing_o;
    logic          begin_v_o;
    logic          pause_v_o;
    logic          fini_v_o;
    logic          done_o;
    logic [SW-1:0] seg_count_o;
    logic [CW-1:0] trace_cycles_o;
    logic          overflow_o;
    logic [1:0]    dbg_state_o;

    final_ctrl #(
        .cnt_width_p   (CW),
        .seg_width_p   (SW),
        .flush_cycles_p(FL)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .arm_i         (arm_i),
        .en_i          (en_i),
        .fini_i        (fini_i),
        .tracing_o     (tracing_o),
        .begin_v_o     (begin_v_o),
        .pause_v_o     (pause_v_o),
        .fini_v_o      (fini_v_o),
        .done_o        (done_o),
        .seg_count_o   (seg_count_o),
        .trace_cycles_o(trace_cycles_o),
        .overflow_o    (overflow_o),
        .dbg_state_o   (dbg_state_o)
    );

    wire [VW-1:0] dut_vec = {tracing_o, begin_v_o, pause_v_o, fini_v_o,
                             done_o, overflow_o, seg_count_o, trace_cycles_o};

    // ---------------- scoreboard ----------------
    logic [VW-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    string cur_tag = "init";

    // Pulse tallies and step index, cleared at every reset.
    int n_begin, n_pause, n_fini, n_trace, step_idx;
    int first_begin_at, first_pause_at;

    task automatic check_vec(input string tag, input logic [VW-1:0] obs,
                             input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (tr,b,p,f,dn,ov,seg,cyc)",
                   tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 tracing, 2 flushing, 3 finished
    int m_mode, m_left, m_seg, m_cyc;
    bit m_ovf;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_seg = 0; m_cyc = 0; m_ovf = 0;
        n_begin = 0; n_pause = 0; n_fini = 0; n_trace = 0; step_idx = 0;
        first_begin_at = -1; first_pause_at = -1;
    endtask

    // Evaluates one edge with the current inputs and queues what the
    // outputs must look like right after it.
    task automatic model_edge();
        bit b, p, f;
        b = 0; p = 0; f = 0;
        if (m_mode == 1) begin
            if (m_cyc < CYC_TOP) m_cyc++;
            if (m_cyc == CYC_TOP) m_ovf = 1;
        end
        if (m_mode == 0) begin
            if (fini_i) begin
                m_mode = arm_i ? 2 : 3;
                m_left = FL;
            end else if (arm_i && en_i) begin
                m_mode = 1;
                b = 1;
                if (m_seg < SEG_TOP) begin
                    m_seg++;
                    if (m_seg == SEG_TOP) m_ovf = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (fini_i) begin
                m_mode = 2; m_left = FL; p = 1;
            end else if (!(en_i && arm_i)) begin
                m_mode = 0; p = 1;
            end
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = 3; f = 1;
            end
        end
        exp_q.push_back({(m_mode == 1), b, p, f, (m_mode == 3), m_ovf,
                         SW'(m_seg), CW'(m_cyc)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit arm, input bit en, input bit fini);
        arm_i = arm; en_i = en; fini_i = fini;
        model_edge();
        @(posedge clk);
        #1;
        check_vec(cur_tag, dut_vec, exp_q.pop_front());
        if (begin_v_o) begin
            n_begin++;
            if (first_begin_at < 0) first_begin_at = step_idx;
        end
        if (pause_v_o) begin
            n_pause++;
            if (first_pause_at < 0) first_pause_at = step_idx;
        end
        if (fini_v_o) n_fini++;
        if (tracing_o) n_trace++;
        step_idx++;
    endtask

    task automatic steps(input int n, input bit arm, input bit en, input bit fini);
        for (int i = 0; i < n; i++) step(arm, en, fini);
    endtask

    task automatic do_reset(input string tag);
        arm_i = 0; en_i = 0; fini_i = 0;
        reset_i = 1'b0;
        #1;
        model_reset();
        exp_q.push_back('0);
        check_vec(tag, dut_vec, exp_q.pop_front());
        @(posedge clk);
        #2;
        reset_i = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        model_reset();
        #2;
        do_reset("reset_state");

        // Plain segment: idle 5 cycles, en high for 10, then dropped.
        cur_tag = "seg_basic";
        steps(5, 1, 0, 0);
        steps(10, 1, 1, 0);
        steps(3, 1, 0, 0);
        check_int("seg_basic_begin_step", first_begin_at, 5);
        check_int("seg_basic_pause_step", first_pause_at, 15);
        check_int("seg_basic_trace_hi", n_trace, 10);
        check_int("seg_basic_seg_count", int'(seg_count_o), 1);
        check_int("seg_basic_cycles", int'(trace_cycles_o), 10);

        // Unarmed: en ignored, fini goes straight to DONE without a pulse.
        do_reset("reset_unarmed");
        cur_tag = "unarmed";
        steps(20, 0, 1, 0);
        steps(1, 0, 1, 1);
        check_int("unarmed_done_next", int'(done_o), 1);
        steps(3, 0, 0, 0);
        check_int("unarmed_begins", n_begin, 0);
        check_int("unarmed_finis", n_fini, 0);
        check_int("unarmed_trace_hi", n_trace, 0);

        // fini while ON with en still high: pause, 4 flush cycles, fini, DONE.
        do_reset("reset_flush");
        cur_tag = "flush_from_on";
        steps(3, 1, 1, 0);
        steps(1, 1, 1, 1);
        steps(FL - 1, 1, 1, 0);
        check_int("flush_not_done_yet", int'(done_o), 0);
        steps(1, 1, 1, 0);
        check_int("flush_fini_pulse", int'(fini_v_o), 1);
        for (int i = 0; i < 6; i++) step(1, i[0], 0);
        check_int("flush_pause_cnt", n_pause, 1);
        check_int("flush_fini_cnt", n_fini, 1);
        check_int("flush_done", int'(done_o), 1);

        // Five toggles: segment counter saturates at 3, then cycle counter too.
        do_reset("reset_toggle");
        cur_tag = "toggle_sat";
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0);
            step(1, 0, 0);
        end
        check_int("toggle_begins", n_begin, 5);
        check_int("toggle_pauses", n_pause, 5);
        check_int("toggle_seg_sat", int'(seg_count_o), SEG_TOP);
        check_int("toggle_overflow", int'(overflow_o), 1);
        cur_tag = "cycle_sat";
        steps(20, 1, 1, 0);
        check_int("cycle_sat_value", int'(trace_cycles_o), CYC_TOP);

        // Cycle counter alone saturating also raises overflow.
        do_reset("reset_cyc_only");
        cur_tag = "cyc_only";
        steps(CYC_TOP, 1, 1, 0);
        check_int("cyc_only_no_ovf_yet", int'(overflow_o), 0);
        steps(2, 1, 1, 0);
        check_int("cyc_only_ovf", int'(overflow_o), 1);

        // Asynchronous reset in the middle of FLUSH.
        do_reset("reset_async_prep");
        cur_tag = "async_mid_flush";
        steps(2, 1, 1, 0);
        steps(2, 1, 1, 1);
        #3;
        reset_i = 1'b0;
        #1;
        model_reset();
        exp_q.push_back('0);
        check_vec("async_clear_no_clock", dut_vec, exp_q.pop_front());
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        steps(FL + 2, 0, 0, 0);
        check_int("async_no_fini", n_fini, 0);
        check_int("async_state_off_seg", int'(seg_count_o), 0);

        // arm dropping in ON pauses; en held high waits for arm to return.
        do_reset("reset_arm_drop");
        cur_tag = "arm_drop";
        steps(3, 1, 1, 0);
        steps(3, 0, 1, 0);
        check_int("arm_drop_pause", n_pause, 1);
        check_int("arm_drop_not_tracing", int'(tracing_o), 0);
        steps(2, 1, 1, 0);
        check_int("arm_drop_begins", n_begin, 2);
        check_int("arm_drop_seg", int'(seg_count_o), 2);

        // fini from OFF while armed: full flush with a fini pulse.
        do_reset("reset_off_flush");
        cur_tag = "off_flush";
        steps(1, 1, 0, 1);
        steps(FL + 2, 1, 0, 0);
        check_int("off_flush_fini_cnt", n_fini, 1);
        check_int("off_flush_pauses", n_pause, 0);

        // Random levels on top of the model.
        do_reset("reset_random");
        cur_tag = "random";
        for (int i = 0; i < 60; i++) begin
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 19) == 0));
        end

        check_int("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles long.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/final_ctrl.md
Name: final_ctrl

Overview:
- Synthesizable trace-window controller.
- Converts a level trace-enable request into registered begin/pause events and tracks the traced-segment count and traced-cycle count.
- On an end-of-run request, runs a bounded flush sequence and then parks in a terminal done state.
- Sits beside the debug/trace infrastructure and gates waveform or trace capture hardware.

Parameters:
- cnt_width_p, 32: width of the traced-cycle counter.
- seg_width_p, 8: width of the segment (begin-event) counter.
- flush_cycles_p, 4: number of cycles spent in FLUSH; legal range 1..255.

Ports:
- clk_i  input  1  single clock; all state on posedge.
- reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
- arm_i  input  1  trace destination configured; level.
- en_i  input  1  trace-enable request; level.
- fini_i  input  1  end-of-run/flush request; level, sampled per cycle.
- tracing_o  output  1  capture active (registered).
- begin_v_o  output  1  one-cycle pulse: trace segment began.
- pause_v_o  output  1  one-cycle pulse: trace segment paused.
- fini_v_o  output  1  one-cycle pulse: flush completed.
- done_o  output  1  terminal state reached; sticky.
- seg_count_o  output  seg_width_p  segments begun; saturating.
- trace_cycles_o  output  cnt_width_p  cycles with tracing_o=1; saturating.
- overflow_o  output  1  sticky: either counter saturated.

Behaviour:
- Reset (reset_i=0, asynchronous): state=OFF; all outputs 0, counters 0, flush counter 0. Deassertion takes effect at the next posedge.
- States and next-state rules:
  - OFF
    - fini_i=1 and arm_i=1: go to FLUSH.
    - fini_i=1 and arm_i=0: go to DONE directly; no fini_v_o pulse.
    - arm_i=1 and en_i=1 (no fini_i): go to ON; begin_v_o=1 for one cycle; seg_count_o increments.
    - Otherwise: stay in OFF. With arm_i=0, en_i is ignored.
  - ON
    - fini_i=1: go to FLUSH; pause_v_o=1 for one cycle.
    - en_i=0 or arm_i=0: go to OFF; pause_v_o=1 for one cycle.
    - Otherwise: stay in ON.
  - FLUSH
    - Flush counter loads 0 on entry and increments each cycle.
    - After exactly flush_cycles_p cycles in FLUSH: go to DONE; fini_v_o=1 for one cycle.
    - en_i, arm_i and fini_i are ignored.
  - DONE
    - Absorbing; done_o=1; all inputs ignored until reset.
- Priority: fini_i > en_i/arm_i in every state.
- Outputs:
  - tracing_o=1 exactly when state=ON.
  - All outputs are registered. An input sampled at edge N appears on outputs after edge N (latency 1).
  - begin_v_o, pause_v_o and fini_v_o are never asserted together.
- Counters:
  - trace_cycles_o increments on every edge at which state=ON before the edge (each ON cycle counts once).
  - Both counters saturate at all-ones. Reaching saturation sets overflow_o=1, which stays set until reset.
- Toggling and bounds:
  - en_i toggling every cycle produces alternating begin/pause pulses; ON lasts 1 cycle per segment.
  - No minimum off-time.
- Reset mid-operation (any state, including FLUSH): immediate return to OFF with all outputs 0. No pause or fini pulse is produced.

Test Plan:
- Arm_i=1, raise en_i at cycle 5 for 10 cycles, then drop it -> begin_v_o pulse at cycle 6, tracing_o high cycles 6-15, pause_v_o pulse at cycle 16, seg_count_o=1, trace_cycles_o=10.
- Arm_i=0, en_i=1 for 20 cycles, then fini_i=1 -> tracing_o stays 0, no begin pulse, DONE next cycle, fini_v_o never pulses, done_o=1.
- Arm_i=1, in ON assert fini_i together with en_i=1, flush_cycles_p=4 -> pause_v_o pulse, 4 FLUSH cycles, fini_v_o pulse, done_o=1; later en_i toggles cause no change.
- seg_width_p=2, toggle en_i 5 times with arm_i=1 -> seg_count_o saturates at 3, overflow_o=1 after the 3rd begin, 5 begin and 5 pause pulses.
- Assert reset_i=0 asynchronously mid-FLUSH (between edges) -> outputs clear immediately without a clock; after release, OFF, with no fini_v_o pulse.
- arm_i drops during ON -> pause_v_o pulse and OFF; en_i held 1 starts no new segment until arm_i returns, then begin_v_o pulses and seg_count_o increments.
